// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters into a single ahb_master
// request port; one transfer outstanding at a time.
module ahb_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_read,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*5-1:0]           i_req_sz,
  input  logic [NUM_REQ-1:0]             i_req_wdata_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_wdata,
  output logic [NUM_REQ-1:0]             o_req_ack,
  output logic [NUM_REQ-1:0]             o_req_rddata_valid,
  output logic [DATA_WIDTH-1:0]          o_req_rdata,
  output logic                           o_m_req_valid,
  output logic                           o_m_req_read,
  output logic [ADDR_WIDTH-1:0]          o_m_req_addr,
  output logic [4:0]                     o_m_req_sz,
  output logic                           o_m_req_wdata_valid,
  output logic [DATA_WIDTH-1:0]          o_m_req_wdata,
  input  logic                           i_m_rddata_valid,
  input  logic [DATA_WIDTH-1:0]          i_m_rdata,
  input  logic                           i_m_ahb_busy
);

  localparam int unsigned SZ_W  = 5;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic                   read_q, read_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SZ_W-1:0]        sz_q, sz_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       scan_idx;

  logic                   owner_wvalid;
  logic [DATA_WIDTH-1:0]  owner_wdata;
  logic                   wr_phase;
  logic                   wr_beat;
  logic                   rd_beat;
  logic [CNT_W-1:0]       beat_target;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   last_beat;

  // Owner's write-side view and beat bookkeeping shared by both comb blocks.
  // Write beats are only taken for write transfers so a read owner's strobe
  // can never advance the counter.
  assign owner_wvalid = i_req_wdata_valid[owner_q];
  assign owner_wdata  = i_req_wdata[32'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign wr_phase     = ((state_q == ISSUE) || (state_q == WDATA)) && !read_q;
  assign wr_beat      = wr_phase && owner_wvalid;
  assign rd_beat      = (state_q == RDATA) && i_m_rddata_valid;
  assign beat_target  = CNT_W'(sz_q) + CNT_W'(1);
  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign last_beat    = (cnt_inc == beat_target);

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && i_req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // State and transfer-context registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      sz_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      sz_q     <= sz_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and context update.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    read_d   = read_q;
    addr_d   = addr_q;
    sz_d     = sz_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (!i_m_ahb_busy && win_found) begin
          owner_d = win_idx;
          read_d  = i_req_read[win_idx];
          addr_d  = i_req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          sz_d    = i_req_sz[32'(win_idx)*SZ_W +: SZ_W];
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (read_q) begin
          state_d = RDATA;
        end else if (wr_beat) begin
          cnt_d   = cnt_inc;
          state_d = last_beat ? DRAIN : WDATA;
        end else begin
          state_d = WDATA;
        end
      end
      WDATA: begin
        if (wr_beat) begin
          cnt_d = cnt_inc;
          if (last_beat) state_d = DRAIN;
        end
      end
      RDATA: begin
        if (rd_beat) begin
          cnt_d = cnt_inc;
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!i_m_ahb_busy) begin
          rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; write and read beats are forwarded combinationally.
  always_comb begin
    o_req_ack           = '0;
    o_req_rddata_valid  = '0;
    o_req_rdata         = '0;
    o_m_req_valid       = 1'b0;
    o_m_req_read        = 1'b0;
    o_m_req_addr        = '0;
    o_m_req_sz          = '0;
    o_m_req_wdata_valid = 1'b0;
    o_m_req_wdata       = '0;
    if (state_q == ISSUE) begin
      o_req_ack     = NUM_REQ'(1) << owner_q;
      o_m_req_valid = 1'b1;
      o_m_req_read  = read_q;
      o_m_req_addr  = addr_q;
      o_m_req_sz    = sz_q;
    end
    if (wr_phase) begin
      o_m_req_wdata_valid = owner_wvalid;
      o_m_req_wdata       = owner_wdata;
    end
    if (rd_beat) begin
      o_req_rddata_valid = NUM_REQ'(1) << owner_q;
      o_req_rdata        = i_m_rdata;
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Randomized plus directed bench for ahb_req_arbiter with a transaction-level
// reference model compared on every cycle.
module tb_ahb_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N-1:0]    i_req_valid, i_req_read, i_req_wdata_valid;
  logic [N*AW-1:0] i_req_addr;
  logic [N*5-1:0]  i_req_sz;
  logic [N*DW-1:0] i_req_wdata;
  logic [N-1:0]    o_req_ack, o_req_rddata_valid;
  logic [DW-1:0]   o_req_rdata;
  logic            o_m_req_valid, o_m_req_read, o_m_req_wdata_valid;
  logic [AW-1:0]   o_m_req_addr;
  logic [4:0]      o_m_req_sz;
  logic [DW-1:0]   o_m_req_wdata;
  logic            i_m_rddata_valid, i_m_ahb_busy;
  logic [DW-1:0]   i_m_rdata;

  always #5 clk = ~clk;

  ahb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_read(i_req_read), .i_req_addr(i_req_addr),
    .i_req_sz(i_req_sz), .i_req_wdata_valid(i_req_wdata_valid), .i_req_wdata(i_req_wdata),
    .o_req_ack(o_req_ack), .o_req_rddata_valid(o_req_rddata_valid), .o_req_rdata(o_req_rdata),
    .o_m_req_valid(o_m_req_valid), .o_m_req_read(o_m_req_read), .o_m_req_addr(o_m_req_addr),
    .o_m_req_sz(o_m_req_sz), .o_m_req_wdata_valid(o_m_req_wdata_valid),
    .o_m_req_wdata(o_m_req_wdata), .i_m_rddata_valid(i_m_rddata_valid),
    .i_m_rdata(i_m_rdata), .i_m_ahb_busy(i_m_ahb_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transfer is "held" from grant to release; it is first
  // announced, then moves beats until sz+1 are done, then waits for the
  // master to go idle before the pointer moves past its owner.
  bit          m_held, m_announced, m_done;
  int          m_owner, m_beats, m_ptr;
  bit          m_read;
  logic [31:0] m_addr;
  logic [4:0]  m_sz;

  // Observed-event logs used by the directed literal checks.
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [N-1:0] rown[$];
  int          ack_log[$];
  int          ack_cyc[$];
  int          mv_cnt;
  logic [31:0] mv_addr;
  logic [4:0]  mv_sz;
  logic        mv_read;

  initial begin
    m_held = 0; m_announced = 0; m_done = 0;
    m_owner = 0; m_beats = 0; m_ptr = 0; m_read = 0; m_addr = '0; m_sz = '0;
    mv_cnt = 0; mv_addr = '0; mv_sz = '0; mv_read = 0;
  end

  // Compare process: mid-cycle, inputs stable, then advance the model.
  always @(negedge clk) begin
    logic [N-1:0] e_ack, e_rv;
    logic e_mv, e_mr, e_wv;
    logic [AW-1:0] e_ma;
    logic [4:0] e_ms;
    logic [DW-1:0] e_wd, e_rd;
    int w;
    e_ack = '0; e_rv = '0; e_mv = 0; e_mr = 0; e_wv = 0;
    e_ma = '0; e_ms = '0; e_wd = '0; e_rd = '0;
    if (m_held && !m_announced) begin
      e_ack[m_owner] = 1'b1; e_mv = 1'b1; e_mr = m_read; e_ma = m_addr; e_ms = m_sz;
    end
    if (m_held && !m_read && !m_done) begin
      e_wv = i_req_wdata_valid[m_owner];
      e_wd = i_req_wdata[m_owner*DW +: DW];
    end
    if (m_held && m_read && m_announced && !m_done && i_m_rddata_valid) begin
      e_rv[m_owner] = 1'b1; e_rd = i_m_rdata;
    end
    if (chk_en) begin
      chk("ack", o_req_ack, e_ack);
      chk("rddata_valid", o_req_rddata_valid, e_rv);
      chk("rdata", o_req_rdata, e_rd);
      chk("m_req_valid", o_m_req_valid, e_mv);
      chk("m_req_read", o_m_req_read, e_mr);
      chk("m_req_addr", o_m_req_addr, e_ma);
      chk("m_req_sz", o_m_req_sz, e_ms);
      chk("m_wdata_valid", o_m_req_wdata_valid, e_wv);
      chk("m_wdata", o_m_req_wdata, e_wd);
    end
    for (int j = 0; j < N; j++)
      if (o_req_ack[j]) begin ack_log.push_back(j); ack_cyc.push_back(cyc); end
    if (o_m_req_wdata_valid) wq.push_back(o_m_req_wdata);
    if (o_req_rddata_valid != 0) begin rq.push_back(o_req_rdata); rown.push_back(o_req_rddata_valid); end
    if (o_m_req_valid) begin
      mv_cnt++; mv_addr = o_m_req_addr; mv_sz = o_m_req_sz; mv_read = o_m_req_read;
    end
    // advance model to the next cycle
    if (i_reset) begin
      m_held = 0; m_announced = 0; m_done = 0; m_beats = 0; m_ptr = 0; m_owner = 0;
    end else if (!m_held) begin
      if (!i_m_ahb_busy) begin
        w = -1;
        for (int j = 0; j < N; j++)
          if (w < 0 && i_req_valid[(m_ptr + j) % N]) w = (m_ptr + j) % N;
        if (w >= 0) begin
          m_held = 1; m_announced = 0; m_done = 0; m_beats = 0; m_owner = w;
          m_read = i_req_read[w]; m_addr = i_req_addr[w*AW +: AW]; m_sz = i_req_sz[w*5 +: 5];
        end
      end
    end else if (!m_announced) begin
      m_announced = 1;
      if (!m_read && i_req_wdata_valid[m_owner]) begin
        m_beats = 1;
        if (m_beats == int'(m_sz) + 1) m_done = 1;
      end
    end else if (m_done) begin
      if (!i_m_ahb_busy) begin
        m_ptr = (m_owner + 1) % N; m_held = 0; m_done = 0;
      end
    end else if ((!m_read && i_req_wdata_valid[m_owner]) || (m_read && i_m_rddata_valid)) begin
      m_beats++;
      if (m_beats == int'(m_sz) + 1) m_done = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clr();
    wq.delete(); rq.delete(); rown.delete(); ack_log.delete(); ack_cyc.delete(); mv_cnt = 0;
  endtask

  task automatic zero_inputs();
    i_req_valid = '0; i_req_read = '0; i_req_addr = '0; i_req_sz = '0;
    i_req_wdata_valid = '0; i_req_wdata = '0;
    i_m_rddata_valid = 0; i_m_rdata = '0; i_m_ahb_busy = 0;
  endtask

  task automatic set_req(input int k, input bit rd, input logic [31:0] a, input logic [4:0] s);
    i_req_valid[k] = 1'b1; i_req_read[k] = rd;
    i_req_addr[k*AW +: AW] = a; i_req_sz[k*5 +: 5] = s;
  endtask

  task automatic wait_ack(input int k, input int budget);
    bit ok;
    ok = 0;
    for (int t = 0; t < budget && !ok; t++) begin
      tick();
      if (o_req_ack[k]) ok = 1;
    end
    chk($sformatf("ack_wait_req%0d", k), ok, 1'b1);
  endtask

  task automatic do_reset();
    i_reset = 1; tick(); tick(); i_reset = 0;
  endtask

  logic [31:0] wvals[4];
  logic [31:0] rvals[4];
  int exp_order[5];
  int drop_cyc, cnt;

  initial begin
    wvals = '{32'h1234, 32'h4567, 32'h89AB, 32'hCDEF};
    rvals = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hDEAD_0003, 32'hBEEF_0004};
    exp_order = '{0, 1, 2, 3, 0};
    zero_inputs();
    i_reset = 1;
    tick(); tick(); tick();
    chk_en = 1;
    i_reset = 0;

    // reset state
    chk("rst_ack", o_req_ack, 0);
    chk("rst_m_valid", o_m_req_valid, 0);
    chk("rst_rdv", o_req_rddata_valid, 0);

    // single write, 4 beats from the ack cycle
    clr();
    set_req(0, 0, 32'hC000_0000, 5'd3);
    wait_ack(0, 10);
    i_req_valid[0] = 0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      i_req_wdata_valid[0] = 1; i_req_wdata[0*DW +: DW] = wvals[b];
    end
    tick(); i_req_wdata_valid[0] = 0;
    repeat (4) tick();
    chk("wr_mvalid_pulses", mv_cnt, 1);
    chk("wr_addr", mv_addr, 32'hC000_0000);
    chk("wr_sz", mv_sz, 3);
    chk("wr_read", mv_read, 0);
    chk("wr_beats", wq.size(), 4);
    if (wq.size() == 4) for (int b = 0; b < 4; b++) chk($sformatf("wr_beat%0d", b), wq[b], wvals[b]);

    // single read from requester 1
    clr();
    set_req(1, 1, 32'hC000_0000, 5'd3);
    wait_ack(1, 10);
    i_req_valid[1] = 0;
    for (int b = 0; b < 4; b++) begin
      tick(); i_m_rddata_valid = 1; i_m_rdata = rvals[b];
    end
    tick(); i_m_rddata_valid = 0;
    repeat (4) tick();
    chk("rd_beats", rq.size(), 4);
    if (rq.size() == 4)
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("rd_data%0d", b), rq[b], rvals[b]);
        chk($sformatf("rd_owner%0d", b), rown[b], 4'b0010);
      end

    // contention from reset
    do_reset();
    clr();
    for (int k = 0; k < N; k++) begin set_req(k, 0, 32'h100 * k, 5'd0); i_req_wdata_valid[k] = 1; end
    for (int t = 0; t < 60 && ack_log.size() < 5; t++) tick();
    i_req_valid = '0; i_req_wdata_valid = '0;
    repeat (4) tick();
    chk("cont_ack_count", ack_log.size() >= 5, 1);
    if (ack_log.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("cont_order%0d", i), ack_log[i], exp_order[i]);
        if (i > 0) chk($sformatf("cont_gap%0d", i), (ack_cyc[i] - ack_cyc[i-1]) >= 3, 1);
      end

    // busy hold in IDLE, then sz=0 write with beat in the ack cycle
    clr();
    i_m_ahb_busy = 1;
    set_req(2, 0, 32'h2000, 5'd0); i_req_wdata_valid[2] = 1; i_req_wdata[2*DW +: DW] = 32'h77;
    repeat (6) tick();
    chk("busy_no_ack", ack_log.size(), 0);
    drop_cyc = cyc;
    i_m_ahb_busy = 0;
    wait_ack(2, 10);
    chk("busy_ack_latency", cyc - drop_cyc, 1);
    i_req_valid[2] = 0;
    repeat (3) tick();
    i_req_wdata_valid[2] = 0;
    repeat (3) tick();
    chk("sz0_single_beat", wq.size(), 1);

    // sz=31 read: exactly 32 beats routed despite 40 offered
    clr();
    set_req(1, 1, 32'h3000, 5'd31);
    wait_ack(1, 10);
    i_req_valid[1] = 0;
    repeat (40) begin tick(); i_m_rddata_valid = 1; i_m_rdata = $urandom; end
    tick(); i_m_rddata_valid = 0;
    repeat (3) tick();
    chk("sz31_beats", rq.size(), 32);
    cnt = 0;
    foreach (rown[i]) if (rown[i] == 4'b0010) cnt++;
    chk("sz31_owner", cnt, 32);

    // reset during a read after 2 of 4 beats
    clr();
    set_req(2, 1, 32'h4000, 5'd3);
    wait_ack(2, 10);
    i_req_valid[2] = 0;
    repeat (2) begin tick(); i_m_rddata_valid = 1; i_m_rdata = $urandom; end
    tick(); i_m_rddata_valid = 0; i_reset = 1;
    tick(); i_reset = 0;
    i_m_rddata_valid = 1; i_m_rdata = 32'hFFFF_0000;
    chk("abort_rdv", o_req_rddata_valid, 0);
    chk("abort_rdata", o_req_rdata, 0);
    chk("abort_ack", o_req_ack, 0);
    chk("abort_mvalid", o_m_req_valid, 0);
    chk("abort_wvalid", o_m_req_wdata_valid, 0);
    chk("abort_beats_before", rq.size(), 2);
    clr();
    set_req(1, 0, 32'h5000, 5'd0); i_req_wdata_valid[1] = 1;
    set_req(3, 0, 32'h6000, 5'd0); i_req_wdata_valid[3] = 1;
    tick(); i_m_rddata_valid = 0;
    for (int t = 0; t < 30 && ack_log.size() < 2; t++) tick();
    i_req_valid = '0; i_req_wdata_valid = '0;
    repeat (4) tick();
    chk("post_rst_acks", ack_log.size() >= 2, 1);
    if (ack_log.size() >= 2) begin
      chk("post_rst_first", ack_log[0], 1);
      chk("post_rst_second", ack_log[1], 3);
    end

    // randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (o_req_ack[k]) i_req_valid[k] = 0;
        else if (!i_req_valid[k]) begin
          if ($urandom_range(3) == 0)
            set_req(k, 1'($urandom_range(1)), $urandom,
                    ($urandom_range(19) == 0) ? 5'd31 : 5'($urandom_range(7)));
        end else if ($urandom_range(15) == 0) i_req_valid[k] = 0;
        i_req_wdata[k*DW +: DW] = $urandom;
      end
      i_req_wdata_valid = N'($urandom);
      i_m_rddata_valid  = 1'($urandom_range(1));
      i_m_rdata         = $urandom;
      i_m_ahb_busy      = ($urandom_range(4) == 0);
      i_reset           = ($urandom_range(399) == 0);
    end
    zero_inputs(); i_reset = 0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
